// File: rtl/result_display.sv
// Signed binary to 5-digit BCD converter with a multiplexed 7-segment scan.
// Define RESULT_DISPLAY_LZB_EN to blank leading-zero digits.
module result_display #(
    parameter int WIDTH       = 16,
    parameter int REFRESH_CNT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic [6:0]       seg,
    output logic [5:0]       an
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        SHIFT,
        LATCH
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] mag;
    logic            neg_t;
    logic [SW-1:0]   sh_cnt;
    logic [19:0]     bcd;
    logic [19:0]     bcd_nxt;
    logic [19:0]     disp;

    logic [CW-1:0]   ref_cnt;
    logic [2:0]      idx;
    logic [3:0]      cur;
    logic            blank;
    logic [6:0]      seg_nxt;

    function automatic logic [19:0] dd_step(input logic [19:0] b,
                                            input logic bit_in);
        logic [19:0] a;
        a = b;
        for (int i = 0; i < 5; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return (a << 1) | {19'd0, bit_in};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign bcd_nxt = dd_step(bcd, mag[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            neg    <= 1'b0;
            neg_t  <= 1'b0;
            mag    <= '0;
            sh_cnt <= '0;
            bcd    <= '0;
            disp   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        mag   <= value;
                        busy  <= 1'b1;
                        state <= ABS;
                    end
                end
                ABS: begin
                    // 0 - mag is exact for the most negative input as unsigned
                    neg_t  <= mag[WIDTH-1];
                    mag    <= mag[WIDTH-1] ? ('0 - mag) : mag;
                    bcd    <= '0;
                    sh_cnt <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    bcd    <= bcd_nxt;
                    mag    <= mag << 1;
                    sh_cnt <= sh_cnt + 1'b1;
                    if (sh_cnt == SW'(WIDTH - 1)) begin
                        // result lands in disp/neg as done goes high in LATCH
                        disp  <= bcd_nxt;
                        neg   <= neg_t;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cur = 4'd0;
        case (idx)
            3'd0:    cur = disp[3:0];
            3'd1:    cur = disp[7:4];
            3'd2:    cur = disp[11:8];
            3'd3:    cur = disp[15:12];
            3'd4:    cur = disp[19:16];
            default: cur = 4'd0;
        endcase
    end

    always_comb begin
        blank = 1'b0;
`ifdef RESULT_DISPLAY_LZB_EN
        case (idx)
            3'd1:    blank = (disp[19:4] == 16'd0);
            3'd2:    blank = (disp[19:8] == 12'd0);
            3'd3:    blank = (disp[19:12] == 8'd0);
            3'd4:    blank = (disp[19:16] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        seg_nxt = 7'b1111111;
        if (idx == 3'd5)
            seg_nxt = neg ? 7'b0111111 : 7'b1111111;
        else if (blank)
            seg_nxt = 7'b1111111;
        else
            seg_nxt = enc(cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= 3'd0;
            an      <= 6'b111111;
            seg     <= 7'b1111111;
        end else begin
            if (ref_cnt == CW'(REFRESH_CNT - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            an  <= ~(6'd1 << idx);
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display against an arithmetic reference model.
// Honors RESULT_DISPLAY_LZB_EN the same way as the design.
module tb_result_display;

    localparam int W  = 16;
    localparam int RC = 4;

    localparam logic [6:0] ENC [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] value;
    logic         load;
    logic         busy;
    logic         done;
    logic         neg;
    logic [6:0]   seg;
    logic [5:0]   an;

    int passed = 0;
    int total  = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;

    result_display #(.WIDTH(W), .REFRESH_CNT(RC)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy), .done(done), .neg(neg), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int         m_k   = 0;
    int         m_val = 0;
    int         m_mag = 0;
    bit         m_neg = 1'b0;
    int         m_n   = 0;
    logic [5:0] m_an  = 6'b111111;
    logic [6:0] m_seg = BLANK;
    bit         m_busy;
    bit         m_done;

    function automatic int pow10(int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] model_seg(int i, int mg, bit ng);
        if (i == 5) return ng ? MINUS : BLANK;
`ifdef RESULT_DISPLAY_LZB_EN
        if (i > 0 && mg < pow10(i)) return BLANK;
`endif
        return ENC[(mg / pow10(i)) % 10];
    endfunction

    function automatic logic [6:0] lz(logic [6:0] lit);
`ifdef RESULT_DISPLAY_LZB_EN
        return (lit == ENC[0]) ? BLANK : lit;
`else
        return lit;
`endif
    endfunction

    // k = cycles since the accepted load; 0 means idle
    assign m_busy = (m_k >= 1) && (m_k <= W + 1);
    assign m_done = (m_k == W + 2);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k   <= 0;
            m_mag <= 0;
            m_neg <= 1'b0;
            m_n   <= 0;
            m_an  <= 6'b111111;
            m_seg <= BLANK;
        end else begin
            m_n   <= m_n + 1;
            m_an  <= ~(6'd1 << ((m_n / RC) % 6));
            m_seg <= model_seg((m_n / RC) % 6, m_mag, m_neg);
            if (m_k == 0) begin
                if (load) begin
                    m_k   <= 1;
                    m_val <= int'($signed(value));
                end
            end else if (m_k == W + 1) begin
                m_k   <= W + 2;
                m_mag <= (m_val < 0) ? -m_val : m_val;
                m_neg <= (m_val < 0);
            end else if (m_k == W + 2) begin
                m_k <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        #2;
        if (done === 1'b1) done_seen++;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("neg", 32'(neg), 32'(m_neg));
            chk("an", 32'(an), 32'(m_an));
            chk("seg", 32'(seg), 32'(m_seg));
        end
    end

    task automatic scan(int i, logic [6:0] exp, string name);
        logic [5:0] tgt;
        bit hit = 1'b0;
        tgt = ~(6'd1 << i);
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            #3;
            if (an === tgt) hit = 1'b1;
        end
        if (!hit) chk({name, "_an_timeout"}, 32'(an), 32'(tgt));
        else chk(name, 32'(seg), 32'(exp));
    endtask

    task automatic run_load(logic [W-1:0] v, int extra_at,
                            output int lat, output int busy_n);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        value  = W'($urandom);
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            #3;
            if (done) begin
                lat = i;
            end else begin
                if (busy) busy_n++;
                if (i == extra_at) begin
                    value = 16'd1;
                    load  = 1'b1;
                end
                @(negedge clk);
                load = 1'b0;
            end
        end
    endtask

    int lat, bn, d0;

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_an", 32'(an), 32'h3f);
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("first_an", 32'(an), 32'b111110);

        run_load(16'd1234, 0, lat, bn);
        chk("lat_1234", 32'(lat), 32'd18);
        chk("busy_1234", 32'(bn), 32'd17);
        chk("neg_1234", 32'(neg), 32'd0);
        scan(4, lz(7'b1000000), "d4_1234");
        scan(3, 7'b1111001, "d3_1234");
        scan(2, 7'b0100100, "d2_1234");
        scan(1, 7'b0110000, "d1_1234");
        scan(0, 7'b0011001, "d0_1234");
        scan(5, BLANK, "s_1234");

        run_load(16'hC080, 0, lat, bn);
        chk("lat_c080", 32'(lat), 32'd18);
        chk("neg_c080", 32'(neg), 32'd1);
        scan(4, 7'b1111001, "d4_c080");
        scan(3, 7'b0000010, "d3_c080");
        scan(2, 7'b0100100, "d2_c080");
        scan(1, 7'b0010010, "d1_c080");
        scan(0, 7'b0000010, "d0_c080");
        scan(5, MINUS, "s_c080");

        d0 = done_seen;
        run_load(16'h8000, 5, lat, bn);
        chk("lat_8000", 32'(lat), 32'd18);
        chk("neg_8000", 32'(neg), 32'd1);
        repeat (30) @(negedge clk);
        #3;
        chk("done_cnt_8000", 32'(done_seen - d0), 32'd1);
        scan(4, 7'b0110000, "d4_8000");
        scan(3, 7'b0100100, "d3_8000");
        scan(2, 7'b1111000, "d2_8000");
        scan(1, 7'b0000010, "d1_8000");
        scan(0, 7'b0000000, "d0_8000");

        run_load(16'd5, 0, lat, bn);
        chk("neg_5", 32'(neg), 32'd0);
        scan(4, lz(7'b1000000), "d4_5");
        scan(3, lz(7'b1000000), "d3_5");
        scan(2, lz(7'b1000000), "d2_5");
        scan(1, lz(7'b1000000), "d1_5");
        scan(0, 7'b0010010, "d0_5");

        @(negedge clk);
        value = 16'd9999;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        d0  = done_seen;
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk("rst_mid_an", 32'(an), 32'h3f);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #3;
        chk("rst_mid_done", 32'(done_seen - d0), 32'd0);
        chk("rst_mid_neg", 32'(neg), 32'd0);
        for (int i = 0; i < 5; i++)
            scan(i, (i == 0) ? 7'b1000000 : lz(7'b1000000), "d_rst");

        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 9))
                0:       value = 16'h8000;
                1:       value = 16'h7fff;
                2:       value = 16'h0000;
                3:       value = 16'hffff;
                default: value = W'($urandom);
            endcase
            load = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (25) @(negedge clk);
        #3;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter WIDTH, default 16: width of the signed two's-complement input value.
REQ-002 Parameter REFRESH_CNT, default 50000: clk cycles each digit is lit during display scanning.
REQ-003 clk  input  1  Single clock; all state changes on the rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 value  input  WIDTH  Signed result to display; sampled only when load is accepted.
REQ-006 load  input  1  Single-cycle request to convert value; accepted only in IDLE.
REQ-007 busy  output  1  High while a conversion is in progress (ABS or SHIFT state).
REQ-008 done  output  1  One-cycle pulse when new digits are latched.
REQ-009 neg  output  1  Latched sign of the last converted value.
REQ-010 seg  output  7  Segment drive {g,f,e,d,c,b,a}, active-low.
REQ-011 an  output  6  Digit anodes, active-low, one-hot-low; an[0]=units ... an[4]=ten-thousands, an[5]=sign.

Function
REQ-012 FSM SHALL have states IDLE, ABS, SHIFT and LATCH.
REQ-013 Transitions SHALL be IDLE->ABS on load, ABS->SHIFT, SHIFT->LATCH after exactly WIDTH shift cycles, and LATCH->IDLE.
REQ-014 ABS SHALL register neg_t=value[WIDTH-1] and mag=|value| as a WIDTH-bit unsigned number, so that the most negative value maps to 2^(WIDTH-1) without overflow.
REQ-015 SHIFT SHALL perform one double-dabble iteration per cycle into a 5-digit BCD register: add 3 to each nibble >=5, then shift left one bit, MSB of mag first.
REQ-016 LATCH SHALL copy the BCD digits and neg_t into the display registers, and done SHALL be asserted for that single cycle.
REQ-017 done SHALL rise exactly WIDTH+2 cycles after the load cycle (18 cycles at default WIDTH).
REQ-018 load while busy or in LATCH SHALL be ignored, with no queuing.
REQ-019 Display registers SHALL hold the previous result until LATCH, so the scan never shows partial conversions.
REQ-020 Refresh counter behaviour:
- counts 0..REFRESH_CNT-1, then wraps to 0;
- on each wrap, the digit index advances 0->1->...->5->0;
- an and seg SHALL change together in the same cycle.
REQ-021 Digit encodings (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 Sign position (index 5) SHALL show minus (0111111) when neg=1 and blank (1111111) otherwise.
REQ-023 The scan SHALL run continuously, independent of FSM state.

Reset
REQ-024 On rst, all of the following SHALL be reset asynchronously:
- FSM -> IDLE; busy=0, done=0, neg=0;
- BCD and display digit registers -> 0;
- refresh counter and digit index -> 0;
- an=111111, seg=1111111.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse, and the display SHALL show 0 after reset is released.
REQ-026 The first scan step after reset release SHALL drive an=111110.

Configuration
REQ-027 Macro RESULT_DISPLAY_LZB_EN:
- when defined, leading-zero digits at index 4 down to 1 SHALL be blanked (1111111), and the units digit SHALL always be shown;
- when undefined, all five digits SHALL be displayed, including leading zeros.

Verification
REQ-028 value=16'd1234, load -> busy for 17 cycles, done at cycle 18, digits 0,1,2,3,4 (index4..0), neg=0, sign blank.
REQ-029 value=16'hC080 (-16256) -> neg=1, digits 1,6,2,5,6, index5 seg=0111111.
REQ-030 value=16'h8000 -> neg=1, digits 3,2,7,6,8; a load pulse at cycle 5 is ignored, and exactly one done pulse occurs.
REQ-031 value=16'd5 with RESULT_DISPLAY_LZB_EN -> indices 4..1 seg=1111111, index0=0010010; without the macro, indices 4..1 seg=1000000.
REQ-032 REFRESH_CNT=4 -> an steps 111110,111101,...,011111,111110, every 4 cycles.
REQ-033 rst pulsed 8 cycles into a conversion of 9999 -> no done pulse, all digits 0, an=111111 during reset.
